// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the merge arbiter and its output buffer.
//   FLIT_W            : flit width; addr occupies [ADDR_MSB:ADDR_LSB], payload below it
//   flit_t            : one flit
//   tagged_flit_t     : a flit together with the index of the input that supplied it
package noc_pkg;

    localparam int FLIT_W   = 9;
    localparam int ADDR_MSB = 8;
    localparam int ADDR_LSB = 5;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic  src;
        flit_t flit;
    } tagged_flit_t;

endpackage

// File: rtl/flit_fifo.sv
// Small circular buffer holding tagged flits between arbitration and the output.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   push, push_data : write push_data at the tail on this edge
//   pop             : drop the head entry on this edge (caller guarantees count > 0)
//   head            : current head entry; while empty, the last entry popped (0 after reset)
//   count           : number of stored entries, 0..DEPTH
module flit_fifo
    import noc_pkg::*;
#(
    parameter int  DEPTH  = 2,
    parameter type elem_t = tagged_flit_t,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  elem_t            push_data,
    input  logic             pop,
    output elem_t            head,
    output logic [CNT_W-1:0] count
);

    elem_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    elem_t            last_q;

    // Pointers are exactly log2(DEPTH) bits wide and DEPTH is a power of two,
    // so plain increment wraps modulo DEPTH.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count qualifies every read, so
    // stale contents are never visible and the array maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // While empty the head shows the last flit that left, so the output holds steady.
    assign head = (count != '0) ? mem[rd_ptr] : last_q;

endmodule

// File: rtl/merge_arbiter2.sv
// Two-input round-robin merge with a small output buffer.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   in0_valid/in0_ready/in0_data    : child 0 valid/ready channel
//   in1_valid/in1_ready/in1_data    : child 1 valid/ready channel
//   out_valid/out_ready/out_data    : merged valid/ready channel
//   out_src                         : index of the child that supplied out_data
// At most one child is accepted per edge. On a tie the child that did not win
// the previous accepted transfer is granted. Accepted flits are buffered, so
// there is always at least one cycle from accept to output.
module merge_arbiter2 #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [FLIT_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [FLIT_W-1:0] in1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_src
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Same layout as noc_pkg::tagged_flit_t, but following this instance's FLIT_W.
    typedef struct packed {
        logic              src;
        logic [FLIT_W-1:0] flit;
    } entry_t;

    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           tail;
    logic             last_winner;
    logic             pop;
    logic             space;
    logic             acc0;
    logic             acc1;
    logic             push;

    assign out_valid = (count != '0);
    assign out_data  = head.flit;
    assign out_src   = head.src;

    assign pop   = out_valid && out_ready;
    // A full buffer still has room when its head leaves on the same edge.
    assign space = (count < FULL_CNT) || pop;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a ready unassigned and infer a latch.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (rst_n && space) begin
            if (in0_valid && in1_valid) begin
                in0_ready = last_winner;
                in1_ready = !last_winner;
            end else begin
                in0_ready = in0_valid;
                in1_ready = in1_valid;
            end
        end
    end

    assign acc0      = in0_valid && in0_ready;
    assign acc1      = in1_valid && in1_ready;
    assign push      = acc0 || acc1;
    assign tail.src  = acc1;
    assign tail.flit = acc1 ? in1_data : in0_data;

    // Reset value 1 makes the first tie go to in0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_winner <= 1'b1;
        end else if (push) begin
            last_winner <= acc1;
        end
    end

    flit_fifo #(
        .DEPTH  (DEPTH),
        .elem_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (tail),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: doc/merge_arbiter2.md
MERGE_ARBITER2 -- requirements
Module: merge_arbiter2

Interface
REQ-001 Parameter FLIT_W, default 9, flit width: addr [8:5], payload [4:0].
REQ-002 Parameter DEPTH, default 2, output buffer entries; legal values 2 and 4.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 _RESET  input  1  reset, synchronous, active-low.
REQ-005 in0_valid  input  1  child 0 flit offered.
REQ-006 in0_ready  output  1  child 0 flit accepted this edge when in0_valid is also high.
REQ-007 in0_data  input  FLIT_W  child 0 flit.
REQ-008 in1_valid, in1_ready, in1_data: as REQ-005..007 for child 1.
REQ-009 out_valid  output  1  merged flit available.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_data  output  FLIT_W  merged flit.
REQ-012 out_src  output  1  source of out_data (0 = in0, 1 = in1); valid with out_valid.

Function
REQ-013 Transfer on any channel occurs on a rising CLK edge where valid and ready are both high.
REQ-014 Sources hold valid and data stable until transfer; the block holds out_valid, out_data and out_src stable until transfer.
REQ-015 At most one input is accepted per cycle.
REQ-016 space = (count < DEPTH) or (out_valid and out_ready); accept is possible only when space is high.
REQ-017 Exactly one of in0/in1 valid and space high: that input's ready is high.
REQ-018 Both valid and space high: grant goes to the input not equal to last_winner; the other input's ready is low.
REQ-019 last_winner updates to the granted index only on an accepted transfer; it holds otherwise.
REQ-020 in0_ready/in1_ready are combinational from valids, last_winner, count and out_ready; no dependency on in*_data.
REQ-021 The accepted flit and its source bit are written to the FIFO tail; the FIFO head drives out_data/out_src.
REQ-022 Latency: a flit accepted at edge N is presented on out at cycle N+1 at the earliest; no combinational input-to-output bypass.
REQ-023 Throughput: one flit per cycle sustained while out_ready is high.
REQ-024 Full (count = DEPTH) with simultaneous pop: push and pop both occur; count is unchanged.
REQ-025 Empty: out_valid low; out_data/out_src hold their last values (0 after reset).
REQ-026 count ranges 0..DEPTH; read and write pointers wrap modulo DEPTH.
REQ-027 Flit bits pass unmodified; no address decoding is performed in this block.
REQ-028 Order is preserved per source and globally in grant order.

Reset
REQ-029 While _RESET is low at a rising edge: count=0, pointers=0, last_winner=1 (first tie goes to in0), out_valid=0, out_data=0, out_src=0.
REQ-030 in0_ready and in1_ready are forced low while _RESET is low.
REQ-031 Reset asserted mid-transfer discards all buffered flits; no flit is emitted after reset until a new accept.

Structure
REQ-032 Shared package noc_pkg holds FLIT_W, ADDR_MSB=8, ADDR_LSB=5, typedef flit_t, and typedef tagged_flit_t {src, flit}.
REQ-033 One sub-module, flit_fifo (parameter DEPTH, element tagged_flit_t, push/pop/count interface), holds the buffer; arbitration stays in merge_arbiter2.

Verification
REQ-034 Reset, then in0 sends 0x0C5 with out_ready=1 -> out_valid high next cycle, out_data=0x0C5, out_src=0.
REQ-035 Both inputs valid continuously (in0=0x101, in1=0x1E2) with out_ready=1 -> out_src alternates 0,1,0,1...; no flit lost or duplicated.
REQ-036 out_ready=0, in1 streams 0x0A0,0x0A1,0x0A2 -> two accepted, in1_ready low on the third; after out_ready=1 the outputs are 0x0A0, 0x0A1, 0x0A2 in order.
REQ-037 FIFO full, out_ready=1 and in0 valid in the same cycle -> pop and push both occur, count stays at 2, in0_ready high.
REQ-038 _RESET low for one cycle while holding 2 flits -> out_valid low the next cycle, last_winner=1, and the next tie is granted to in0.
REQ-039 Random valid/ready stress over 10k cycles -> scoreboard matches per-source order, and out_src is consistent with source.
